// File: rtl/hangman_round_if.sv
// hangman_round_if: guess/word inputs and round status outputs of the Hangman round controller.
interface hangman_round_if #(parameter int WORD_LEN = 5);
    logic                  go;
    logic [4:0]            guess;
    logic [5*WORD_LEN-1:0] word;
    logic                  new_game;
    logic [WORD_LEN-1:0]   found;
    logic [2:0]            misses;
    logic                  hit;
    logic                  miss;
    logic                  dup;
    logic                  won;
    logic                  lost;
    modport master (output go, guess, word, new_game, input found, misses, hit, miss, dup, won, lost);
    modport slave  (input go, guess, word, new_game, output found, misses, hit, miss, dup, won, lost);
endinterface

// File: rtl/hangman_round_ctrl.sv
// hangman_round_ctrl: one Hangman round; evaluates each guess on go release, tracks found/misses, declares win/loss.
module hangman_round_ctrl #(
    parameter int         WORD_LEN   = 5,
    parameter int         MAX_MISSES = 6,
    parameter logic [4:0] BLANK      = 5'b11111
) (
    input logic           clk,
    input logic           rst,
    hangman_round_if.slave bus
);
    typedef enum logic [2:0] {PLAY, HOLD, EVAL, RESULT, WON, LOST} state_t;
    state_t              state_q;
    logic                go_q;
    logic [4:0]          guess_q;
    logic [25:0]         used_q;
    logic [WORD_LEN-1:0] found_q;
    logic [2:0]          misses_q;
    logic                hit_q, miss_q, dup_q, won_q, lost_q;
    logic [WORD_LEN-1:0] match, blank_mask;
    for (genvar i = 0; i < WORD_LEN; i++) begin : g_pos
        assign blank_mask[i] = bus.word[5*i +: 5] == BLANK;
        assign match[i]      = bus.word[5*i +: 5] == guess_q && !blank_mask[i];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= PLAY;
            go_q     <= 1'b0;
            guess_q  <= '0;
            used_q   <= '0;
            found_q  <= '0;
            misses_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            dup_q    <= 1'b0;
            won_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            go_q  <= bus.go;
            hit_q <= 1'b0;
            miss_q <= 1'b0;
            dup_q <= 1'b0;
            if (bus.new_game) begin
                state_q  <= PLAY;
                used_q   <= '0;
                found_q  <= '0;
                misses_q <= '0;
                won_q    <= 1'b0;
                lost_q   <= 1'b0;
            end else begin
                case (state_q)
                    PLAY: if (bus.go && !go_q && bus.guess <= 5'd25) begin
                        guess_q <= bus.guess;
                        state_q <= HOLD;
                    end
                    HOLD: if (!bus.go) state_q <= EVAL;
                    EVAL: begin
                        state_q <= RESULT;
                        if (used_q[guess_q]) dup_q <= 1'b1;
                        else begin
                            used_q[guess_q] <= 1'b1;
                            if (|match) begin
                                found_q <= found_q | match;
                                hit_q   <= 1'b1;
                            end else begin
                                misses_q <= misses_q == 3'(MAX_MISSES) ? misses_q : misses_q + 3'd1;
                                miss_q   <= 1'b1;
                            end
                        end
                    end
                    RESULT: begin
                        // win is checked first; the last reveal never coincides with a miss
                        if (&(found_q | blank_mask)) begin
                            state_q <= WON;
                            won_q   <= 1'b1;
                        end else if (misses_q == 3'(MAX_MISSES)) begin
                            state_q <= LOST;
                            lost_q  <= 1'b1;
                        end else state_q <= PLAY;
                    end
                    default: ;
                endcase
            end
        end
    end
    assign bus.found  = found_q;
    assign bus.misses = misses_q;
    assign bus.hit    = hit_q;
    assign bus.miss   = miss_q;
    assign bus.dup    = dup_q;
    assign bus.won    = won_q;
    assign bus.lost   = lost_q;
endmodule

// File: tb/tb_hangman_round_ctrl.sv
// tb_hangman_round_ctrl: directed checks of guess evaluation, pulses, win/loss and restart behaviour.
module tb_hangman_round_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [2:0] p, p_after;
    hangman_round_if #(.WORD_LEN(5)) bus ();
    hangman_round_ctrl #(.WORD_LEN(5), .MAX_MISSES(6), .BLANK(5'b11111)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // press for 3 cycles, release; pulses sampled two cycles after release and once more after
    task automatic play(input logic [4:0] g, output logic [2:0] pulses, output logic [2:0] after);
        bus.guess = g;
        bus.go = 1'b1;
        repeat (3) @(negedge clk);
        bus.go = 1'b0;
        repeat (2) @(negedge clk);
        pulses = {bus.hit, bus.miss, bus.dup};
        @(negedge clk);
        after = {bus.hit, bus.miss, bus.dup};
    endtask
    task automatic restart();
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        bus.go = 1'b0;
        bus.guess = '0;
        bus.new_game = 1'b0;
        bus.word = {5'd31, 5'd24, 5'd0, 5'd19, 5'd18};
        #1;
        chk("reset_state", {bus.found, bus.misses, bus.won, bus.lost, bus.hit, bus.miss, bus.dup}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        play(5'd19, p, p_after);
        chk("t_pulse", p, 3'b100);
        chk("t_pulse_one_cycle", p_after, 3'b000);
        chk("t_found", {bus.found, bus.misses}, {5'b00010, 3'd0});
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {bus.found, bus.misses, bus.won, bus.lost}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        play(5'd19, p, p_after);
        chk("t_again_after_reset", {p, bus.found}, {3'b100, 5'b00010});
        play(5'd25, p, p_after);
        chk("z_miss", {p, bus.misses}, {3'b010, 3'd1});
        play(5'd25, p, p_after);
        chk("z_dup", {p, bus.misses, bus.found}, {3'b001, 3'd1, 5'b00010});
        play(5'd30, p, p_after);
        chk("invalid_ignored", {p, p_after, bus.misses, bus.found}, {6'b0, 3'd1, 5'b00010});
        play(5'd18, p, p_after);
        chk("s_after_invalid", {p, bus.found}, {3'b100, 5'b00011});
        play(5'd0, p, p_after);
        chk("a_hit", {p, bus.found, bus.won}, {3'b100, 5'b00111, 1'b0});
        play(5'd24, p, p_after);
        chk("y_win", {p, bus.found, bus.won, bus.lost}, {3'b100, 5'b01111, 2'b10});
        play(5'd1, p, p_after);
        chk("won_frozen", {p, bus.found, bus.misses, bus.won}, {3'b000, 5'b01111, 3'd1, 1'b1});
        restart();
        chk("new_game_after_win", {bus.found, bus.misses, bus.won, bus.lost}, '0);
        for (int i = 1; i <= 5; i++) begin
            play(5'(i), p, p_after);
            chk("loss_miss", {p, bus.misses, bus.lost}, {3'b010, 3'(i), 1'b0});
        end
        play(5'd6, p, p_after);
        chk("sixth_miss", {p, bus.misses, bus.lost, bus.won}, {3'b010, 3'd6, 2'b10});
        play(5'd7, p, p_after);
        chk("lost_frozen", {p, bus.misses, bus.found, bus.lost}, {3'b000, 3'd6, 5'b0, 1'b1});
        restart();
        bus.word = {5'd31, 5'd10, 5'd14, 5'd14, 5'd1};
        play(5'd14, p, p_after);
        chk("book_o", {p, p_after, bus.found}, {3'b100, 3'b000, 5'b00110});
        play(5'd20, p, p_after);
        chk("book_u_miss", {p, bus.misses}, {3'b010, 3'd1});
        bus.guess = 5'd10;
        bus.go = 1'b1;
        repeat (2) @(negedge clk);
        bus.go = 1'b0;
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_abort_quiet", {bus.hit, bus.miss, bus.dup, bus.found, bus.misses}, '0);
        end
        play(5'd10, p, p_after);
        chk("k_after_abort", {p, bus.found, bus.misses}, {3'b100, 5'b01000, 3'd0});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hangman_round_ctrl.md
Name: hangman_round_ctrl

Overview:
- Sequences one round of Hangman: captures a 5-bit letter guess on each go press and compares it against all letter positions of the current word.
- Accumulates a per-position found mask and counts wrong guesses.
- Declares win or loss.
- Sits between the KEY/SW inputs and the HEX display datapath. Its found mask drives the per-position letter reveal; misses drives the gallows/LEDR display.

Parameters:
WORD_LEN, 5, number of letter positions in the word
MAX_MISSES, 6, wrong guesses that end the round as lost (1..7)
BLANK, 5'b11111, letter code marking an unused position in a shorter word

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
go  input  1  guess button level, already inverted to active-high, already synchronised
guess  input  5  letter code 0..25 (A=0 .. Z=25)
word  input  5*WORD_LEN  word letters; position i = word[5i+4:5i]; must be stable during a round
new_game  input  1  synchronous restart of the round, level-sensitive
found  output  WORD_LEN  bit i = 1 when position i has been guessed
misses  output  3  count of distinct wrong guesses
hit  output  1  one-cycle pulse: the evaluated guess matched at least one position
miss  output  1  one-cycle pulse: the evaluated guess was new and wrong
dup  output  1  one-cycle pulse: the evaluated guess letter was already used
won  output  1  level: round won
lost  output  1  level: round lost

Behaviour:
- Reset (async, active-high), effective immediately:
  - state=PLAY; found=0; misses=0; used=0 (internal 26-bit used-letter mask); go_d=0.
  - hit/miss/dup=0; won/lost=0.
- States: PLAY, HOLD, EVAL, RESULT, WON, LOST.
- Edge detection: go_d is go registered every cycle. A press is go=1 while go_d=0.
- PLAY, on a press:
  - Latch guess into guess_q and go to HOLD.
  - If guess > 25, do not latch it; stay in PLAY. Such a press is ignored entirely, with no pulses and no state change.
- HOLD: wait while go=1. On go=0, go to EVAL. Evaluation therefore happens on button release.
- EVAL, one cycle; all updates take effect at the clock edge ending EVAL:
  - If used[guess_q]=1: dup=1 next cycle. found, misses and used are unchanged.
  - Otherwise set used[guess_q].
    - Match vector m[i] = (word letter i == guess_q) and (word letter i != BLANK).
    - If m != 0: found |= m and hit=1. Every duplicate occurrence of the letter is revealed at once.
    - If m == 0: misses += 1 and miss=1.
  - Next state is RESULT.
- Pulses hit, miss and dup are registered. Each is high for exactly the RESULT cycle.
- RESULT:
  - Let done = &(found | blank_mask), where blank_mask[i] = (word letter i == BLANK).
  - If done, go to WON.
  - Else if misses == MAX_MISSES, go to LOST.
  - Else go to PLAY.
  - Win has priority; a miss cannot coincide with completion in any case.
- WON: won=1, held. go is ignored. found and misses are frozen.
- LOST: lost=1, held. go is ignored. found is frozen so that the unrevealed positions stay dark.
- won and lost are registered. They assert in the cycle after RESULT and are never both 1.
- new_game=1 in any state, at the next edge:
  - Same effect as reset: found=0, misses=0, used=0, state=PLAY, pulses 0, won/lost 0.
  - new_game has priority over every other transition, including in-flight HOLD and EVAL.
- A press pending while in WON or LOST does not carry over after new_game. Only a fresh rising edge seen in PLAY counts.
- misses saturates at MAX_MISSES. It never wraps.
- Latency: go falling, sampled in HOLD → EVAL (+1) → hit/miss/dup and updated found/misses (+2) → won/lost (+3).
- The word input is only compared in EVAL and RESULT. Changing it mid-round is unsupported.

Test Plan:
- Setup for all scenarios: word = {BLANK, Y=24, A=0, T=19, S=18} (STAY, position 0 = S).
- Reset behaviour: assert reset mid-clock → found=0, misses=0, won=0, lost=0 without waiting for a clk edge. Release → state PLAY.
- Correct guess: guess=19, press go 3 cycles, release → hit=1 for exactly one cycle 2 cycles after release. found=5'b00010, misses=0.
- Wrong and repeated guesses:
  - guess=25 (Z) → miss pulse, misses=1.
  - guess=25 again → dup pulse, misses stays 1.
  - guess=30 → no pulse, no state change; the next valid press is still accepted.
- Win: guess 18, 0, 24 after the T → found=5'b01111, won=1 one cycle after the final RESULT cycle.
  - A further press changes nothing.
  - new_game → found=0, won=0.
- Loss: six distinct wrong letters (1, 2, 3, 4, 5, 6) → misses=6, lost=1 after the sixth RESULT cycle. A seventh press is ignored and misses stays 6.
- Duplicate letters and interrupted rounds:
  - word = {BLANK, 10, 14, 14, 1} (BOOK); guess 14 → found=5'b00110 with a single hit pulse.
  - new_game asserted during HOLD → no evaluation; found and misses clear.
